// File: rtl/universal_shift_reg_pkg.sv
// Shared mode encodings and select type for the universal shift register.
package universal_shift_reg_pkg;

  typedef logic [1:0] usr_sel_t;

  localparam usr_sel_t USR_HOLD = 2'b00;
  localparam usr_sel_t USR_SHR  = 2'b01;
  localparam usr_sel_t USR_SHL  = 2'b10;
  localparam usr_sel_t USR_LOAD = 2'b11;

endpackage

// File: rtl/universal_shift_reg.sv
// N-bit universal shift register: hold, shift right, shift left or parallel load each clock.
// The parallel output comes straight from the state flops, so it never depends combinationally on inputs.
module universal_shift_reg
  import universal_shift_reg_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             slin_i,
  input  logic             srin_i,
  input  usr_sel_t         sel_i,
  input  logic [WIDTH-1:0] pin_i,
  output logic [WIDTH-1:0] pout_o
);

  logic [WIDTH-1:0] q_r;

  // State register: one operation per edge; unknown selects fall through to hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r <= '0;
    end else begin
      case (sel_i)
        USR_HOLD: q_r <= q_r;
        USR_SHR:  q_r <= {srin_i, q_r[WIDTH-1:1]};
        USR_SHL:  q_r <= {q_r[WIDTH-2:0], slin_i};
        USR_LOAD: q_r <= pin_i;
        default:  q_r <= q_r;
      endcase
    end
  end

  assign pout_o = q_r;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Self-checking bench for universal_shift_reg: directed scenarios plus randomized run against an arithmetic model.
module tb_universal_shift_reg;

  logic       clk;
  logic       rst_n;
  logic       slin;
  logic       srin;
  logic [1:0] sel;
  logic [3:0] pin;
  logic [3:0] pout;

  int checks;
  int failures;

  universal_shift_reg #(.WIDTH(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .slin_i (slin),
    .srin_i (srin),
    .sel_i  (sel),
    .pin_i  (pin),
    .pout_o (pout)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Drive inputs, take one rising edge, then settle 1 ns past it for sampling.
  task automatic cycle(input logic [1:0] s, input logic [3:0] p, input logic sl, input logic sr);
    sel  = s;
    pin  = p;
    slin = sl;
    srin = sr;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sel = 2'b11; pin = 4'b1010; slin = 1'b0; srin = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (pout !== 4'b0000) begin
      failures++; $display("FAIL reset_hold got=%b want=0000", pout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycle(2'b11, 4'b1010, 1'b0, 1'b0);
    checks++;
    if (pout !== 4'b1010) begin
      failures++; $display("FAIL reset_release_load got=%b want=1010", pout);
    end
    #4 rst_n = 1'b0;
    #1;
    checks++;
    if (pout !== 4'b0000) begin
      failures++; $display("FAIL reset_async_clear got=%b want=0000", pout);
    end
    #2 rst_n = 1'b1;
  endtask

  task automatic test_load_hold();
    cycle(2'b11, 4'b1101, 1'b0, 1'b0);
    checks++;
    if (pout !== 4'b1101) begin
      failures++; $display("FAIL load got=%b want=1101", pout);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(2'b00, 4'b0010, 1'b1, 1'b1);
      checks++;
      if (pout !== 4'b1101) begin
        failures++; $display("FAIL hold_%0d got=%b want=1101", i, pout);
      end
    end
  endtask

  task automatic test_shift_right();
    logic [3:0] exp_a [2] = '{4'b1110, 4'b1111};
    logic [3:0] exp_b [4] = '{4'b0100, 4'b0010, 4'b0001, 4'b0000};
    cycle(2'b11, 4'b1101, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      cycle(2'b01, 4'b0000, 1'b0, 1'b1);
      checks++;
      if (pout !== exp_a[i]) begin
        failures++; $display("FAIL shr_in1_%0d got=%b want=%b", i, pout, exp_a[i]);
      end
    end
    cycle(2'b11, 4'b1000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(2'b01, 4'b1111, 1'b1, 1'b0);
      checks++;
      if (pout !== exp_b[i]) begin
        failures++; $display("FAIL shr_in0_%0d got=%b want=%b", i, pout, exp_b[i]);
      end
    end
  endtask

  task automatic test_shift_left();
    logic [3:0] exp_a [3] = '{4'b0011, 4'b0111, 4'b1111};
    cycle(2'b11, 4'b0001, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(2'b10, 4'b0000, 1'b1, 1'b0);
      checks++;
      if (pout !== exp_a[i]) begin
        failures++; $display("FAIL shl_in1_%0d got=%b want=%b", i, pout, exp_a[i]);
      end
    end
    cycle(2'b11, 4'b1001, 1'b0, 1'b0);
    cycle(2'b10, 4'b1111, 1'b0, 1'b1);
    checks++;
    if (pout !== 4'b0010) begin
      failures++; $display("FAIL shl_msb_drop got=%b want=0010", pout);
    end
  endtask

  task automatic test_isolation();
    cycle(2'b11, 4'b0110, 1'b0, 1'b0);
    cycle(2'b01, 4'b1001, 1'b1, 1'b0);
    checks++;
    if (pout !== 4'b0011) begin
      failures++; $display("FAIL iso_shr got=%b want=0011", pout);
    end
    cycle(2'b10, 4'b0000, 1'b0, 1'b1);
    checks++;
    if (pout !== 4'b0110) begin
      failures++; $display("FAIL iso_shl got=%b want=0110", pout);
    end
    cycle(2'b11, 4'b1010, 1'b1, 1'b1);
    checks++;
    if (pout !== 4'b1010) begin
      failures++; $display("FAIL iso_load got=%b want=1010", pout);
    end
    // Changing inputs between edges must not reach the output.
    pin = 4'b0101; slin = 1'b0; srin = 1'b0;
    #5;
    checks++;
    if (pout !== 4'b1010) begin
      failures++; $display("FAIL iso_no_comb got=%b want=1010", pout);
    end
  endtask

  task automatic test_reset_mid_shift();
    cycle(2'b11, 4'b0110, 1'b0, 1'b0);
    cycle(2'b01, 4'b0000, 1'b0, 1'b1);
    #4 rst_n = 1'b0;
    #1;
    checks++;
    if (pout !== 4'b0000) begin
      failures++; $display("FAIL mid_reset_clear got=%b want=0000", pout);
    end
    #4 rst_n = 1'b1;
    cycle(2'b01, 4'b0000, 1'b0, 1'b1);
    checks++;
    if (pout !== 4'b1000) begin
      failures++; $display("FAIL mid_reset_resume got=%b want=1000", pout);
    end
  endtask

  task automatic test_random();
    int model;
    int s, p, sl, sr;
    model = 4'b1000;
    for (int i = 0; i < 300; i++) begin
      s  = $urandom_range(3, 0);
      p  = $urandom_range(15, 0);
      sl = $urandom_range(1, 0);
      sr = $urandom_range(1, 0);
      cycle(s[1:0], p[3:0], sl[0], sr[0]);
      if (s == 1)      model = model / 2 + sr * 8;
      else if (s == 2) model = (model * 2 + sl) % 16;
      else if (s == 3) model = p;
      checks++;
      if (pout !== model[3:0]) begin
        failures++;
        $display("FAIL rand_%0d sel=%0d got=%b want=%b", i, s, pout, model[3:0]);
      end
      if ($urandom_range(24, 0) == 0) begin
        #3 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        model = 0;
        checks++;
        if (pout !== 4'b0000) begin
          failures++; $display("FAIL rand_reset_%0d got=%b want=0000", i, pout);
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_load_hold();
    test_shift_right();
    test_shift_left();
    test_isolation();
    test_reset_mid_shift();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
